hwpe_ctrl_periph_target: RTL

- Responder (slave) end of the HWPE peripheral control protocol: req/gnt, add, wen, be, data, id, then r_data/r_valid/r_id.
- Terminates transactions from a cluster-side initiator into a bank of NB_REGS 32-bit read/write registers plus one read-only status word.
- Programmable wait-state insertion before grant.
- Sits between the peripheral interconnect and an accelerator's config/status logic, and serves as the bench-side memory-mapped target.

---
 rtl/hwpe_ctrl_periph_target.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/hwpe_ctrl_periph_target.sv
// Peripheral-protocol responder: NB_REGS byte-writable RW registers plus one read-only status word.
// Latency: grant after WAIT_CYCLES extra cycles of held req; response one cycle after accept.
// Backpressure: the initiator is stalled by withholding gnt; responses are never stalled.
module hwpe_ctrl_periph_target #(
  parameter int          ID_WIDTH    = 8,
  parameter int          NB_REGS     = 8,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] RESET_VAL   = 32'h0,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  periph_req_i,
  output logic                  periph_gnt_o,
  input  logic [31:0]           periph_add_i,
  input  logic                  periph_wen_i,
  input  logic [3:0]            periph_be_i,
  input  logic [31:0]           periph_data_i,
  input  logic [ID_WIDTH-1:0]   periph_id_i,
  output logic [31:0]           periph_r_data_o,
  output logic                  periph_r_valid_o,
  output logic [ID_WIDTH-1:0]   periph_r_id_o,
  input  logic [31:0]           status_i,
  output logic [32*NB_REGS-1:0] reg_o,
  output logic [NB_REGS-1:0]    reg_wr_o
);

  // One extra index value is needed to address the status word at NB_REGS.
  localparam int IDX_W = $clog2(NB_REGS + 1);
  localparam int CNT_W = 4;
  localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NB_REGS);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_CYCLES);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt_raw;
  logic              accept;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       rd_data;
  logic [31:0]       regs_q [NB_REGS];
  logic              unused_add;

  // Only the word-index bits of the address are decoded; the rest are don't-care.
  assign idx        = periph_add_i[IDX_W+1:2];
  assign unused_add = ^{periph_add_i[31:IDX_W+2], periph_add_i[1:0]};

  // Grant is forced low while in reset so nothing can be accepted then.
  assign periph_gnt_o = gnt_raw & ~rst_i;
  assign accept       = periph_req_i & periph_gnt_o;

  // Wait-state FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and grant: every transaction waits the full WAIT_CYCLES, even back-to-back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_raw = 1'b0;
    if (WAIT_CYCLES == 0) begin
      state_d = IDLE;
      cnt_d   = '0;
      gnt_raw = periph_req_i;
    end else begin
      case (state_q)
        IDLE: begin
          if (periph_req_i) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
        WAIT: begin
          if (!periph_req_i) begin
            // Initiator withdrew the request: abandon it without a transaction.
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == WAIT_LAST) begin
            gnt_raw = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Read mux: RW registers, then status, then the error pattern for unmapped words.
  always_comb begin
    rd_data = ERR_DATA;
    if (idx == STATUS_IDX) begin
      rd_data = status_i;
    end
    for (int k = 0; k < NB_REGS; k++) begin
      if (idx == IDX_W'(k)) begin
        rd_data = regs_q[k];
      end
    end
  end

  // Register bank with per-byte write enables; writes to status/unmapped words are dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NB_REGS; k++) begin
        regs_q[k] <= RESET_VAL;
      end
    end else if (accept && !periph_wen_i) begin
      for (int k = 0; k < NB_REGS; k++) begin
        if (idx == IDX_W'(k)) begin
          for (int b = 0; b < 4; b++) begin
            if (periph_be_i[b]) begin
              regs_q[k][8*b +: 8] <= periph_data_i[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Write strobe: one-cycle pulse per written register, independent of byte enables.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reg_wr_o <= '0;
    end else begin
      reg_wr_o <= '0;
      if (accept && !periph_wen_i) begin
        for (int k = 0; k < NB_REGS; k++) begin
          reg_wr_o[k] <= (idx == IDX_W'(k));
        end
      end
    end
  end

  // Response channel: valid for exactly one cycle per accept; data/id hold otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      periph_r_valid_o <= 1'b0;
      periph_r_data_o  <= '0;
      periph_r_id_o    <= '0;
    end else begin
      periph_r_valid_o <= accept;
      if (accept) begin
        periph_r_id_o   <= periph_id_i;
        periph_r_data_o <= periph_wen_i ? rd_data : 32'h0;
      end
    end
  end

  // Flatten the bank onto the register output bus.
  for (genvar k = 0; k < NB_REGS; k++) begin : g_reg_out
    assign reg_o[32*k +: 32] = regs_q[k];
  end

endmodule
